// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats and the ID/EX register layout.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            rd_en;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic            illegal;
    } id_ex_t;

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I decode: legality, register usage and sign-extended immediate.
module rv32i_decoder
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output logic            illegal,
    output logic            rs1_used,
    output logic            rs2_used,
    output logic            rd_wr,
    output logic [XLEN-1:0] imm
);

    imm_fmt_e fmt;
    logic     rd_written;

    always_comb begin
        illegal    = 1'b1;
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        rd_written = 1'b0;
        fmt        = IMM_NONE;
        if (instr[1:0] == 2'b11) begin
            case (instr[6:0])
                OP_LUI, OP_AUIPC: begin
                    illegal = 1'b0; rd_written = 1'b1; fmt = IMM_U;
                end
                OP_JAL: begin
                    illegal = 1'b0; rd_written = 1'b1; fmt = IMM_J;
                end
                OP_JALR, OP_LOAD, OP_IMM: begin
                    illegal = 1'b0; rd_written = 1'b1; rs1_used = 1'b1; fmt = IMM_I;
                end
                OP_BRANCH: begin
                    illegal = 1'b0; rs1_used = 1'b1; rs2_used = 1'b1; fmt = IMM_B;
                end
                OP_STORE: begin
                    illegal = 1'b0; rs1_used = 1'b1; rs2_used = 1'b1; fmt = IMM_S;
                end
                OP_OP: begin
                    illegal = 1'b0; rd_written = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
                end
                OP_MISC_MEM, OP_SYSTEM: begin
                    illegal = 1'b0;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

    // Writes to x0 are discarded, so they never claim the scoreboard.
    assign rd_wr = rd_written & (instr[11:7] != 5'd0);

    always_comb begin
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'd0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register file read ports, busy scoreboard and valid/ready ID/EX register.
module id_stage
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic            rs1_en,
    output logic            rs2_en,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic            ex_rd_en,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            ex_illegal,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            flush
);

    logic            dec_illegal;
    logic            dec_rs1_used;
    logic            dec_rs2_used;
    logic            dec_rd_wr;
    logic [XLEN-1:0] dec_imm;
    logic [4:0]      rd;
    logic            stall;
    logic            issue;
    logic            ex_valid_q;
    id_ex_t          ex_q;
    id_ex_t          ex_d;
    logic [31:0]     busy;
    logic [31:0]     busy_nxt;

    rv32i_decoder u_decoder (
        .instr    (if_instr),
        .illegal  (dec_illegal),
        .rs1_used (dec_rs1_used),
        .rs2_used (dec_rs2_used),
        .rd_wr    (dec_rd_wr),
        .imm      (dec_imm)
    );

    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign rd     = if_instr[11:7];
    assign rs1_en = if_valid & dec_rs1_used;
    assign rs2_en = if_valid & dec_rs2_used;

    // Busy is sampled before this cycle's writeback clears it: no bypass.
    assign stall    = if_valid & ((dec_rs1_used & busy[rs1]) |
                                  (dec_rs2_used & busy[rs2]) |
                                  (dec_rd_wr    & busy[rd]));
    assign id_ready = !stall & !flush & (!ex_valid_q | ex_ready);
    assign issue    = if_valid & id_ready;

    always_comb begin
        ex_d          = '0;
        ex_d.pc       = if_pc;
        ex_d.rs1_data = rs1_data;
        ex_d.rs2_data = rs2_data;
        ex_d.imm      = dec_imm;
        ex_d.rd       = rd;
        ex_d.rd_en    = dec_rd_wr;
        ex_d.opcode   = if_instr[6:0];
        ex_d.funct3   = if_instr[14:12];
        ex_d.funct7b5 = if_instr[30];
        ex_d.illegal  = dec_illegal;
    end

    // Clears first so that a same-cycle set on the same index wins.
    always_comb begin
        busy_nxt = busy;
        if (wb_valid)
            busy_nxt[wb_rd] = 1'b0;
        if (flush & ex_valid_q & !ex_ready & ex_q.rd_en)
            busy_nxt[ex_q.rd] = 1'b0;
        if (issue & dec_rd_wr)
            busy_nxt[rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
            busy       <= '0;
        end else begin
            busy <= busy_nxt;
            if (issue) begin
                ex_q       <= ex_d;
                ex_valid_q <= 1'b1;
            end else if (ex_valid_q & (ex_ready | flush)) begin
                ex_valid_q <= 1'b0;
            end
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_pc       = ex_q.pc;
    assign ex_rs1_data = ex_q.rs1_data;
    assign ex_rs2_data = ex_q.rs2_data;
    assign ex_imm      = ex_q.imm;
    assign ex_rd       = ex_q.rd;
    assign ex_rd_en    = ex_q.rd_en;
    assign ex_opcode   = ex_q.opcode;
    assign ex_funct3   = ex_q.funct3;
    assign ex_funct7b5 = ex_q.funct7b5;
    assign ex_illegal  = ex_q.illegal;

endmodule

// File: doc/id_stage.md
# id_stage

Instruction decode stage of the RV32I core, directly upstream of the register file. Decodes the incoming 32-bit instruction, drives the register file read ports (addresses and enables), and captures operands, immediate and control fields into a valid/ready ID/EX pipeline register. A per-register busy scoreboard stalls issue on RAW/WAW hazards until writeback retires the destination.

## Interface
- XLEN, 32, datapath width; only 32 supported.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- if_valid  in  1  instruction presented
- if_instr  in  32  instruction word
- if_pc  in  32  PC of if_instr
- id_ready  out  1  ID accepts if_instr this cycle
- rs1, rs2  out  5  register file read addresses (if_instr[19:15], [24:20])
- rs1_en, rs2_en  out  1  register file read enables
- rs1_data, rs2_data  in  32  register file read data, same cycle
- ex_valid  out  1  ID/EX register holds an instruction
- ex_ready  in  1  EX consumes ID/EX register
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  32  captured operands, sign-extended immediate
- ex_rd  out  5  destination
- ex_rd_en  out  1  instruction writes ex_rd (never for x0)
- ex_opcode  out  7; ex_funct3  out  3; ex_funct7b5  out  1  control fields
- ex_illegal  out  1  unrecognised encoding
- wb_valid  in  1  writeback retires a register write this cycle
- wb_rd  in  5  register being retired
- flush  in  1  discard ID/EX contents and block issue this cycle

## Operation
- Decode (combinational on if_instr): opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM. Anything else, or instr[1:0]≠2'b11, is illegal.
- Register use: rs1 used by JALR/BRANCH/LOAD/STORE/OP-IMM/OP; rs2 used by BRANCH/STORE/OP; rd written by LUI/AUIPC/JAL/JALR/LOAD/OP-IMM/OP when rd≠0. Illegal: no reads, no write.
- rs1_en/rs2_en = if_valid & used; addresses always driven from the instruction fields.
- Immediate by format: I, S, B (bit0=0), U (low 12 zero), J (bit0=0), sign-extended from instr[31]. R-type, MISC-MEM and SYSTEM: 0.
- Scoreboard busy[31:1]; x0 never busy.
  - Stall when if_valid and (rs1 used & busy[rs1]) or (rs2 used & busy[rs2]) or (rd written & busy[rd]).
  - No writeback bypass: a register retiring this cycle is still busy for this cycle's check.
  - On issue with ex_rd_en: set busy[rd]. On wb_valid with wb_rd≠0: clear busy[wb_rd]. Set and clear of the same index in one cycle: set wins.
- id_ready = !stall & !flush & (!ex_valid | ex_ready). Issue = if_valid & id_ready.
- ID/EX update: on issue, load all ex_* fields and set ex_valid=1; else if ex_valid & ex_ready, clear ex_valid; else hold all fields.
- Flush: if ex_valid & !ex_ready, clear ex_valid and clear busy[ex_rd] when ex_rd_en. If ex_valid & ex_ready, the entry counts as consumed and the scoreboard is untouched. No issue in a flush cycle.

## Timing
- Reset: ex_valid=0, every ex_* output 0, busy all 0. Asynchronous, takes effect mid-operation; contents are lost.
- id_ready, rs1/rs2, rs1_en/rs2_en are combinational from the current inputs and registers.
- Latency: an instruction issued at edge N appears on ex_* from cycle N+1. Throughput is 1/cycle absent hazards.
- While ex_valid & !ex_ready, ex_* are stable.
- A RAW dependency on the immediately preceding instruction stalls until the cycle after wb_valid for that rd.

## Structure
- Package rv32i_pkg: opcode localparams, imm_fmt_e enum (I,S,B,U,J,NONE), id_ex_t struct for the pipeline register fields.
- Sub-module rv32i_decoder: purely combinational opcode/format/use decode plus immediate generation. id_stage holds the scoreboard, handshake and ID/EX register.

## Test plan
- Reset mid-stream with ex_valid=1 → ex_valid=0, all ex_* 0, busy cleared immediately; ADDI issues the next cycle.
- ADDI x5,x0,-1 (0xFFF00293), ex_ready=1 → next cycle ex_imm=0xFFFFFFFF, ex_rd=5, ex_rd_en=1, rs1_en=1, rs2_en=0.
- ADDI x5 then ADD x6,x5,x5 back-to-back → ADD held with id_ready=0 until the cycle after wb_valid, wb_rd=5; then issues with rs1=rs2=5.
- ex_ready=0 for 3 cycles with valid ex entry → id_ready=0, ex_* stable; ex_ready=1 → queued instruction loads the next edge.
- flush with ex_valid=1, ex_ready=0, ex_rd=7 → ex_valid=0 next cycle, busy[7]=0, no issue that cycle.
- if_instr=0x00000000 and opcode 0x7F → ex_illegal=1, ex_rd_en=0, rs1_en=rs2_en=0, no scoreboard change; ADDI x0,x0,0 → ex_rd_en=0.
